// File: rtl/lsa_amo_unit.sv
// Load/store/atomic execution unit: address generation, request FIFO,
// multi-channel load-data broadcast and AMO combine/writeback to the LSU.
module lsa_amo_unit #(
  parameter int unsigned DW    = 32,
  parameter int unsigned IDXW  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCH   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [3:0]      iss_ctrl,
  input  logic [IDXW-1:0] iss_index,
  input  logic [5:0]      iss_type,
  input  logic [DW-1:0]   iss_op1,
  input  logic [DW-1:0]   iss_op2,
  input  logic [DW-1:0]   iss_sdata,
  input  logic [4:0]      iss_areg,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [DW-1:0]   req_addr,
  output logic [DW-1:0]   req_sdata,
  output logic [IDXW-1:0] req_index,
  output logic [5:0]      req_type,
  output logic [4:0]      req_areg,
  input  logic            rsp_valid,
  output logic            rsp_ready,
  input  logic [DW-1:0]   rsp_data,
  input  logic [IDXW-1:0] rsp_index,
  output logic [NCH-1:0]  bc_valid,
  input  logic [NCH-1:0]  bc_ready,
  output logic [DW-1:0]   bc_data,
  output logic [IDXW-1:0] bc_index,
  output logic            amo_valid,
  input  logic            amo_ready,
  output logic [DW-1:0]   amo_data,
  output logic [IDXW-1:0] amo_index
);
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned NCTX = 1 << IDXW;

  typedef struct packed {
    logic [DW-1:0]   addr;
    logic [IDXW-1:0] index;
    logic [5:0]      typ;
    logic [DW-1:0]   sdata;
    logic [4:0]      areg;
  } entry_t;

  entry_t          q_q [DEPTH];
  entry_t          iss_entry, head;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [NCTX-1:0] ctx_vld_q;
  logic [3:0]      ctx_ctrl_q [NCTX];
  logic [DW-1:0]   ctx_op2_q  [NCTX];
  logic [NCH-1:0]  bc_valid_q;
  logic [DW-1:0]   bc_data_q, amo_data_q;
  logic [IDXW-1:0] bc_index_q, amo_index_q;
  logic            amo_valid_q;
  logic            iss_fire, req_fire, rsp_fire, rsp_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Comparisons pick b only on strict win, so ties return a.
  function automatic logic [DW-1:0] amo_f(input logic [3:0] c, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (c)
      4'b1010: return b;
      4'b1111: return a + b;
      4'b0110: return a ^ b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b1011: return ($signed(b) > $signed(a)) ? b : a;
      4'b1101: return ($signed(b) < $signed(a)) ? b : a;
      4'b1100: return (b > a) ? b : a;
      4'b1110: return (b < a) ? b : a;
      default: return '0;
    endcase
  endfunction

  assign rsp_hit   = ctx_vld_q[rsp_index];
  assign iss_ready = !rst && (count_q < CW'(DEPTH)) && !(iss_type[4] && ctx_vld_q[iss_index]);
  assign rsp_ready = !rst && (bc_valid_q == '0) && !(rsp_hit && amo_valid_q);
  assign iss_fire  = iss_valid && iss_ready;
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_comb begin
    iss_entry       = '0;
    iss_entry.addr  = iss_type[4] ? iss_op1 : iss_op1 + iss_op2;
    iss_entry.index = iss_index;
    iss_entry.typ   = iss_type;
    iss_entry.sdata = iss_sdata;
    iss_entry.areg  = iss_areg;
  end

  always_comb begin
    count_d = count_q;
    if (iss_fire && !req_fire)      count_d = count_q + 1'b1;
    else if (!iss_fire && req_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (iss_fire) begin
        q_q[wr_ptr_q] <= iss_entry;
        wr_ptr_q      <= ptr_inc(wr_ptr_q);
      end
      if (req_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  assign head      = q_q[rd_ptr_q];
  assign req_valid = (count_q != '0);
  assign req_addr  = head.addr;
  assign req_sdata = head.sdata;
  assign req_index = head.index;
  assign req_type  = head.typ;
  assign req_areg  = head.areg;

  // A busy index never admits an atomic issue, so release and set cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_vld_q <= '0;
      for (int unsigned i = 0; i < NCTX; i++) begin
        ctx_ctrl_q[i] <= '0;
        ctx_op2_q[i]  <= '0;
      end
    end else begin
      if (rsp_fire && rsp_hit) ctx_vld_q[rsp_index] <= 1'b0;
      if (iss_fire && iss_type[4]) begin
        ctx_vld_q[iss_index]  <= 1'b1;
        ctx_ctrl_q[iss_index] <= iss_ctrl;
        ctx_op2_q[iss_index]  <= iss_op2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_valid_q  <= '0;
      bc_data_q   <= '0;
      bc_index_q  <= '0;
      amo_valid_q <= 1'b0;
      amo_data_q  <= '0;
      amo_index_q <= '0;
    end else begin
      bc_valid_q <= bc_valid_q & ~bc_ready;
      if (amo_ready) amo_valid_q <= 1'b0;
      if (rsp_fire) begin
        bc_valid_q <= '1;
        bc_data_q  <= rsp_data;
        bc_index_q <= rsp_index;
        if (rsp_hit) begin
          amo_valid_q <= 1'b1;
          amo_data_q  <= amo_f(ctx_ctrl_q[rsp_index], rsp_data, ctx_op2_q[rsp_index]);
          amo_index_q <= rsp_index;
        end
      end
    end
  end

  assign bc_valid  = bc_valid_q;
  assign bc_data   = bc_data_q;
  assign bc_index  = bc_index_q;
  assign amo_valid = amo_valid_q;
  assign amo_data  = amo_data_q;
  assign amo_index = amo_index_q;
endmodule

// File: tb/tb_lsa_amo_unit.sv
// Directed and randomized checks of lsa_amo_unit against a queue/array reference model.
module tb_lsa_amo_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_ctrl, iss_index;
  logic [5:0]  iss_type;
  logic [31:0] iss_op1, iss_op2, iss_sdata;
  logic [4:0]  iss_areg;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_sdata;
  logic [3:0]  req_index;
  logic [5:0]  req_type;
  logic [4:0]  req_areg;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_index;
  logic [2:0]  bc_valid, bc_ready;
  logic [31:0] bc_data;
  logic [3:0]  bc_index;
  logic        amo_valid, amo_ready;
  logic [31:0] amo_data;
  logic [3:0]  amo_index;

  lsa_amo_unit #(.DW(32), .IDXW(4), .DEPTH(4), .NCH(3)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ctrl(iss_ctrl), .iss_index(iss_index),
    .iss_type(iss_type), .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_sdata(iss_sdata),
    .iss_areg(iss_areg),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_sdata(req_sdata),
    .req_index(req_index), .req_type(req_type), .req_areg(req_areg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_index(rsp_index),
    .bc_valid(bc_valid), .bc_ready(bc_ready), .bc_data(bc_data), .bc_index(bc_index),
    .amo_valid(amo_valid), .amo_ready(amo_ready), .amo_data(amo_data), .amo_index(amo_index)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  idx;
    logic [5:0]  typ;
    logic [31:0] sdata;
    logic [4:0]  areg;
  } req_t;

  req_t        mq[$];
  bit          m_ctx  [16];
  logic [3:0]  m_ctrl [16];
  logic [31:0] m_op2  [16];
  logic [2:0]  m_bc;
  logic [31:0] m_bcd, m_amod;
  logic [3:0]  m_bci, m_amoi;
  bit          m_amo;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_amo(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int    sa = a;
    int    sb = b;
    longint ua = a;
    longint ub = b;
    case (c)
      4'b1010: return b;
      4'b1111: return a + b;
      4'b0110: return a ^ b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b1011: return (sb > sa) ? b : a;
      4'b1101: return (sb < sa) ? b : a;
      4'b1100: return (ub > ua) ? b : a;
      4'b1110: return (ub < ua) ? b : a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic mreset();
    mq.delete();
    foreach (m_ctx[i]) m_ctx[i] = 1'b0;
    m_bc  = '0;
    m_amo = 1'b0;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    bc_ready  = '1;
    amo_ready = 1'b1;
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [3:0] idx, input logic [5:0] typ,
                       input logic [31:0] op1, input logic [31:0] op2);
    iss_valid = 1'b1;
    iss_ctrl  = ctrl;
    iss_index = idx;
    iss_type  = typ;
    iss_op1   = op1;
    iss_op2   = op2;
    iss_sdata = op1 ^ 32'h5A5A_0000;
    iss_areg  = {1'b0, idx};
  endtask

  // Called just after inputs are driven on the falling edge; checks, then advances the model.
  task automatic step();
    bit   e_ir, e_rr, ifire, pfire, rfire;
    req_t r;
    #1;
    e_ir = (mq.size() < 4) && !(iss_type[4] && m_ctx[iss_index]);
    e_rr = (m_bc == 3'b000) && !(m_ctx[rsp_index] && m_amo);
    chk("iss_ready", iss_ready, e_ir);
    chk("rsp_ready", rsp_ready, e_rr);
    chk("req_valid", req_valid, mq.size() != 0);
    if (mq.size() != 0)
      chk("req_payload", {req_addr, req_index, req_type, req_sdata, req_areg},
          {mq[0].addr, mq[0].idx, mq[0].typ, mq[0].sdata, mq[0].areg});
    chk("bc_valid", bc_valid, m_bc);
    if (m_bc != 3'b000) chk("bc_payload", {bc_data, bc_index}, {m_bcd, m_bci});
    chk("amo_valid", amo_valid, m_amo);
    if (m_amo) chk("amo_payload", {amo_data, amo_index}, {m_amod, m_amoi});
    ifire   = iss_valid && e_ir;
    pfire   = req_ready && (mq.size() != 0);
    rfire   = rsp_valid && e_rr;
    r.addr  = iss_type[4] ? iss_op1 : iss_op1 + iss_op2;
    r.idx   = iss_index;
    r.typ   = iss_type;
    r.sdata = iss_sdata;
    r.areg  = iss_areg;
    @(posedge clk);
    if (pfire) void'(mq.pop_front());
    if (m_amo && amo_ready) m_amo = 1'b0;
    m_bc = m_bc & ~bc_ready;
    if (rfire) begin
      m_bc  = 3'b111;
      m_bcd = rsp_data;
      m_bci = rsp_index;
      if (m_ctx[rsp_index]) begin
        m_amo            = 1'b1;
        m_amod           = ref_amo(m_ctrl[rsp_index], rsp_data, m_op2[rsp_index]);
        m_amoi           = rsp_index;
        m_ctx[rsp_index] = 1'b0;
      end
    end
    if (ifire) begin
      mq.push_back(r);
      if (iss_type[4]) begin
        m_ctx[iss_index]  = 1'b1;
        m_ctrl[iss_index] = iss_ctrl;
        m_op2[iss_index]  = iss_op2;
      end
    end
  endtask

  logic [3:0]  actl [6] = '{4'b1101, 4'b1110, 4'b1011, 4'b1100, 4'b1111, 4'b0000};
  logic [31:0] aexp [6] = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0};

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    issue(4'h0, 4'h0, 6'h00, 32'h0, 32'h0);
    iss_valid = 1'b0;
    rsp_data  = '0;
    rsp_index = '0;
    mreset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_iss_ready", iss_ready, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_bc_valid", bc_valid, 0);
    chk("rst_amo_valid", amo_valid, 0);
    chk("rst_outputs", {req_addr, req_index, bc_data, bc_index, amo_data, amo_index}, 0);

    // Plain load and its broadcast
    @(negedge clk); rst = 1'b0; idle(); issue(4'h0, 4'd3, 6'h02, 32'h1000, 32'h24); step();
    @(negedge clk); idle(); req_ready = 1'b1; #1 chk("load_addr", req_addr, 32'h1024); step();
    @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; rsp_index = 4'd3;
    bc_ready = 3'b000; step();
    @(negedge clk); idle(); #1;
    chk("load_bc_valid", bc_valid, 3'b111);
    chk("load_bc_data", bc_data, 32'hDEAD_BEEF);
    chk("load_no_amo", amo_valid, 0);
    step();

    // Address wrap, non-atomic vs atomic
    @(negedge clk); idle(); issue(4'hF, 4'd1, 6'h02, 32'hFFFF_FFF0, 32'h20); step();
    @(negedge clk); idle(); issue(4'hF, 4'd2, 6'h12, 32'hFFFF_FFF0, 32'h20); req_ready = 1'b1;
    #1 chk("wrap_add", req_addr, 32'h10); step();
    @(negedge clk); idle(); req_ready = 1'b1; #1 chk("wrap_atomic", req_addr, 32'hFFFF_FFF0); step();
    @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'hFFFF_FFFF; rsp_index = 4'd2;
    amo_ready = 1'b0; step();
    @(negedge clk); idle(); #1 chk("wrap_amo_add", amo_data, 32'h1F); step();

    // AMO signed vs unsigned
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); idle(); issue(actl[k], 4'd8, 6'h10, 32'h100, 32'h1); step();
      @(negedge clk); idle(); req_ready = 1'b1; step();
      @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'hFFFF_FFFF; rsp_index = 4'd8;
      amo_ready = 1'b0; step();
      @(negedge clk); idle(); #1 chk($sformatf("amo_result_%0d", k), amo_data, aexp[k]); step();
    end

    // Queue full, then drain in order
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle(); issue(4'h0, 4'(k), 6'h02, 32'(k * 16), 32'h0);
      #1 chk("full_iss_ready", iss_ready, k < 4); step();
    end
    @(negedge clk); idle(); issue(4'h0, 4'd4, 6'h02, 32'd64, 32'h0); req_ready = 1'b1;
    #1 chk("full_pop_ready", iss_ready, 0); chk("drain_0", req_addr, 32'd0); step();
    @(negedge clk); idle(); issue(4'h0, 4'd4, 6'h02, 32'd64, 32'h0); req_ready = 1'b1;
    #1 chk("fifth_ready", iss_ready, 1); chk("drain_1", req_addr, 32'd16); step();
    for (int k = 2; k < 5; k++) begin
      @(negedge clk); idle(); req_ready = 1'b1;
      #1 chk($sformatf("drain_%0d", k), req_addr, 32'(k * 16)); step();
    end

    // Busy-index stall and staggered broadcast
    @(negedge clk); idle(); issue(4'b1010, 4'd5, 6'h10, 32'h200, 32'hAB); step();
    @(negedge clk); idle(); issue(4'b1111, 4'd5, 6'h10, 32'h300, 32'h1); req_ready = 1'b1;
    #1 chk("busy_stall", iss_ready, 0); step();
    @(negedge clk); idle(); issue(4'b1111, 4'd5, 6'h10, 32'h300, 32'h1);
    rsp_valid = 1'b1; rsp_data = 32'h55; rsp_index = 4'd5; bc_ready = 3'b000; amo_ready = 1'b0;
    #1 chk("same_cycle_stall", iss_ready, 0); step();
    @(negedge clk); idle(); issue(4'b1111, 4'd5, 6'h10, 32'h300, 32'h1);
    rsp_valid = 1'b1; rsp_data = 32'h77; rsp_index = 4'd7; bc_ready = 3'b100;
    #1 chk("busy_release", iss_ready, 1); chk("swap", amo_data, 32'hAB);
    chk("stag_rsp_0", rsp_ready, 0); step();
    @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'h77; rsp_index = 4'd7; bc_ready = 3'b010;
    #1 chk("stag_bc_1", bc_valid, 3'b011); chk("stag_rsp_1", rsp_ready, 0); step();
    @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'h77; rsp_index = 4'd7; bc_ready = 3'b001;
    #1 chk("stag_bc_2", bc_valid, 3'b001); chk("stag_rsp_2", rsp_ready, 0); step();
    @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'h77; rsp_index = 4'd7;
    #1 chk("stag_rsp_3", rsp_ready, 1); step();

    // Reset mid-flight with two queued requests and a pending AMO
    @(negedge clk); idle(); issue(4'h0, 4'd9, 6'h02, 32'h400, 32'h4); step();
    @(negedge clk); idle(); rsp_valid = 1'b1; rsp_data = 32'h2; rsp_index = 4'd5; amo_ready = 1'b0;
    step();
    @(negedge clk); idle(); amo_ready = 1'b0;
    #1 chk("pre_rst_amo", amo_valid, 1); chk("pre_rst_qlen", mq.size(), 2);
    chk("pre_rst_req", req_valid, 1);
    rst = 1'b1;
    #1 chk("mid_rst_valids", {req_valid, bc_valid, amo_valid}, 0);
    mreset();
    @(negedge clk);
    @(negedge clk); rst = 1'b0; idle(); issue(4'b1010, 4'd5, 6'h10, 32'h500, 32'h9);
    #1 chk("post_rst_ready", iss_ready, 1); step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      iss_valid    = 1'($urandom_range(0, 1));
      iss_ctrl     = 4'($urandom_range(0, 15));
      iss_index    = 4'($urandom_range(0, 7));
      iss_type     = 6'($urandom);
      iss_type[4]  = ($urandom_range(0, 3) == 0);
      iss_op1      = $urandom;
      iss_op2      = $urandom;
      iss_sdata    = $urandom;
      iss_areg     = 5'($urandom_range(0, 31));
      req_ready    = ($urandom_range(0, 9) < 6);
      rsp_valid    = ($urandom_range(0, 9) < 4);
      rsp_index    = 4'($urandom_range(0, 7));
      rsp_data     = ($urandom_range(0, 7) == 0) ? m_op2[rsp_index] : $urandom;
      bc_ready     = 3'($urandom);
      amo_ready    = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
